// File: rtl/branch_table_updater_if.sv
// Update handshake between a branch-resolution source and the branch table updater.
// valid/ready: an update transfers on a rising clk edge where update_valid and update_ready are both 1;
// the source holds index/tag/taken stable while update_valid is 1 and not yet accepted.
interface branch_table_updater_if #(
    parameter int C_DEPTH      = 512,
    parameter int C_DATA_WIDTH = 20
);
    localparam int AW = $clog2(C_DEPTH);
    localparam int TW = C_DATA_WIDTH - 2;

    logic          update_valid;
    logic          update_ready;
    logic [AW-1:0] update_index;
    logic [TW-1:0] update_tag;
    logic          update_taken;

    modport master (
        output update_valid,
        output update_index,
        output update_tag,
        output update_taken,
        input  update_ready
    );

    modport slave (
        input  update_valid,
        input  update_index,
        input  update_tag,
        input  update_taken,
        output update_ready
    );
endinterface

// File: rtl/branch_table_updater.sv
// Branch-table updater: clears the table after reset, then applies one tagged 2-bit
// saturating-counter update per cycle via a read / modify-write pipeline with forwarding.
module branch_table_updater #(
    parameter int  C_DEPTH      = 512,
    parameter int  C_DATA_WIDTH = 20,
    localparam int AW           = $clog2(C_DEPTH),
    localparam int TW           = C_DATA_WIDTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_table_updater_if.slave   upd,
    output logic [AW-1:0]           ram_read_addr,
    output logic                    ram_read_en,
    input  logic [C_DATA_WIDTH-1:0] ram_read_data,
    output logic [AW-1:0]           ram_write_addr,
    output logic                    ram_write_en,
    output logic [C_DATA_WIDTH-1:0] ram_write_data,
    output logic                    init_done,
    output logic                    state_dbg
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AW-1:0]           sweep_cnt;

    logic                    s1_valid;
    logic [AW-1:0]           s1_index;
    logic [TW-1:0]           s1_tag;
    logic                    s1_taken;

    logic                    fwd_valid;
    logic [AW-1:0]           fwd_index;
    logic [C_DATA_WIDTH-1:0] fwd_entry;

    logic                    running;
    logic                    accept;
    logic [C_DATA_WIDTH-1:0] src_entry;
    logic [C_DATA_WIDTH-1:0] new_entry;
    logic [TW-1:0]           src_tag;
    logic [1:0]              src_cnt;

    // Outputs are qualified with rst so nothing leaks out while reset is held.
    assign running          = rst && (state == ST_RUN);
    assign upd.update_ready = running;
    assign init_done        = running;
    assign state_dbg        = state;
    assign accept           = upd.update_valid && running;

    always_comb begin
        state_next = state;
        if (state == ST_INIT && sweep_cnt == AW'(C_DEPTH - 1)) begin
            state_next = ST_RUN;
        end
    end

    // The forward register covers the one case the RAM cannot: its registered read
    // returned old data because the previous write to this index committed the same edge.
    always_comb begin
        src_entry = ram_read_data;
        if (fwd_valid && fwd_index == s1_index) begin
            src_entry = fwd_entry;
        end
        src_tag = src_entry[C_DATA_WIDTH-1:2];
        src_cnt = src_entry[1:0];

        new_entry = '0;
        if (src_tag == s1_tag) begin
            new_entry[C_DATA_WIDTH-1:2] = src_tag;
            if (s1_taken) begin
                new_entry[1:0] = (src_cnt == 2'b11) ? 2'b11 : src_cnt + 2'd1;
            end else begin
                new_entry[1:0] = (src_cnt == 2'b00) ? 2'b00 : src_cnt - 2'd1;
            end
        end else begin
            new_entry[C_DATA_WIDTH-1:2] = s1_tag;
            new_entry[1:0]              = s1_taken ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ram_read_en    = accept;
        ram_read_addr  = upd.update_index;
        ram_write_en   = 1'b0;
        ram_write_addr = sweep_cnt;
        ram_write_data = '0;
        if (rst) begin
            if (state == ST_INIT) begin
                ram_write_en   = 1'b1;
                ram_write_addr = sweep_cnt;
                ram_write_data = '0;
            end else begin
                ram_write_en   = s1_valid;
                ram_write_addr = s1_index;
                ram_write_data = new_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            s1_valid  <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + AW'(1);
            end
            s1_valid  <= accept;
            fwd_valid <= s1_valid && (state == ST_RUN);
        end
    end

    // Payload registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_index <= upd.update_index;
            s1_tag   <= upd.update_tag;
            s1_taken <= upd.update_taken;
        end
        if (s1_valid) begin
            fwd_index <= s1_index;
            fwd_entry <= new_entry;
        end
    end

endmodule

// File: doc/branch_table_updater.md
BRANCH_TABLE_UPDATER -- requirements
Module: branch_table_updater

Interface
REQ-001 SHALL have parameter C_DEPTH, default 512, number of branch-table entries (power of two, >= 4).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 20, entry width: bits [C_DATA_WIDTH-1:2] are the tag and bits [1:0] are a 2-bit counter.
REQ-003 SHALL have port clk  input  1  the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port update_valid  input  1  a branch-resolution update is offered.
REQ-006 SHALL have port update_ready  output  1  the update is accepted when update_valid and update_ready are both 1.
REQ-007 SHALL have port update_index  input  $clog2(C_DEPTH)  the table index to update.
REQ-008 SHALL have port update_tag  input  C_DATA_WIDTH-2  the branch tag.
REQ-009 SHALL have port update_taken  input  1  the resolved direction (1 = taken).
REQ-010 SHALL have port ram_read_addr  output  $clog2(C_DEPTH)  table RAM read address.
REQ-011 SHALL have port ram_read_en  output  1  table RAM read enable.
REQ-012 SHALL have port ram_read_data  input  C_DATA_WIDTH  table RAM registered read data, valid one cycle after ram_read_en; on read-during-write it returns the old data.
REQ-013 SHALL have port ram_write_addr  output  $clog2(C_DEPTH)  table RAM write address.
REQ-014 SHALL have port ram_write_en  output  1  table RAM write enable.
REQ-015 SHALL have port ram_write_data  output  C_DATA_WIDTH  table RAM write data.
REQ-016 SHALL have port init_done  output  1  the table clear sweep is complete.

Function
REQ-017 SHALL implement states INIT and RUN; reset enters INIT with the sweep counter at 0.
REQ-018 In INIT, SHALL each cycle drive ram_write_en=1, ram_write_addr=sweep counter and ram_write_data=0, then increment the counter; after address C_DEPTH-1 is written it SHALL go to RUN (C_DEPTH cycles total).
REQ-019 In INIT, SHALL hold update_ready=0, init_done=0 and ram_read_en=0.
REQ-020 In RUN, SHALL hold update_ready=1 and init_done=1, sustaining one update per cycle.
REQ-021 Accept in cycle N SHALL drive ram_read_en=1 and ram_read_addr=update_index combinationally in cycle N, and register index, tag and taken into stage 1 (valid bit set).
REQ-022 In cycle N+1, stage 1 SHALL compute the new entry from the source entry and drive ram_write_en=1, ram_write_addr and ram_write_data combinationally; the write commits at the end of N+1 (accept-to-commit latency 2 edges).
REQ-023 Source entry SHALL be the forward register when it is valid and its index equals the stage-1 index; otherwise it SHALL be ram_read_data.
REQ-024 The forward register SHALL capture {index, entry} of every stage-1 write and be valid only in the cycle that immediately follows that write.
REQ-025 Tag hit (source tag == stage-1 tag): taken SHALL increment the counter, saturating at 3; not-taken SHALL decrement it, saturating at 0; the tag is unchanged.
REQ-026 Tag miss: the entry SHALL become {stage-1 tag, taken ? 2'b10 : 2'b01}.
REQ-027 Back-to-back updates to the same index SHALL each observe the result of the previous update, with no stall.
REQ-028 With no stage-1 valid in RUN, SHALL drive ram_write_en=0; with no accept, SHALL drive ram_read_en=0.
REQ-029 update_valid without update_ready (INIT) SHALL cause no RAM access and no state change.

Reset
REQ-030 While rst=0, SHALL clear the stage-1 valid bit, forward valid, init_done, update_ready and sweep counter, and drive ram_read_en=0 and ram_write_en=0.
REQ-031 Reset asserted mid-RUN or mid-INIT SHALL drop any in-flight update without writing it and SHALL restart the sweep at address 0 after release.

Verification
REQ-032 Release reset with C_DEPTH=512 -> 512 consecutive writes of 0 to addresses 0..511, then init_done=1 and update_ready=1 in cycle 513.
REQ-033 Index 5 holding {tag 0x100, 2'b01}, update tag 0x100 taken -> write 5 <= {0x100, 2'b10} one cycle after accept.
REQ-034 Index 7 holding {tag 0x100, 2'b11}, update tag 0x155 not-taken -> write {0x155, 2'b01}; the same index with tag 0x155 and four not-taken updates -> final counter 0, saturated.
REQ-035 Index 3 holding {tag 0xA, 2'b00}, three back-to-back taken tag-0xA updates on consecutive cycles -> successive writes with counters 01, 10, 11 (forwarding exercised).
REQ-036 Alternate updates to index 9 and index 10 with the same tag and 2-bit counters -> no cross-index forwarding; each index counts independently.
REQ-037 rst=0 one cycle after an accept -> no write for that update; sweep restarts at address 0 and table reads 0.
